bus_addr_decoder: RTL

- Parametrised, registered successor to the combinational ROM/RAM select decoder.
- Sits between the CPU data/instruction bus master and NSLV memory/peripheral slaves.
- Decodes each request against per-slave base/mask windows with fixed priority, then drives a one-hot slave select.
- Enforces per-slave wait states, waits for slave acknowledge, and returns data or an error.
- Adds a bus timeout and an unmapped-address error, which the old decoder lacked.

---
 rtl/bus_addr_decoder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/bus_addr_decoder.sv
// rtl/bus_addr_decoder.sv - registered base/mask bus decoder with wait states, ack handshake and timeout
// Fixed-priority window match, one-hot slave select, error on unmapped address or missing ack.
module bus_addr_decoder #(
  parameter int                      ADDR_W   = 13,
  parameter int                      DATA_W   = 32,
  parameter int                      NSLV     = 2,
  parameter logic [NSLV*ADDR_W-1:0]  SLV_BASE = {13'h1800, 13'h0000},
  parameter logic [NSLV*ADDR_W-1:0]  SLV_MASK = {13'h1800, 13'h0000},
  parameter logic [NSLV*4-1:0]       SLV_WAIT = {4'd0, 4'd1},
  parameter int                      TIMEOUT  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m_req,
  input  logic                   m_we,
  input  logic [ADDR_W-1:0]      m_addr,
  input  logic [DATA_W-1:0]      m_wdata,
  output logic [DATA_W-1:0]      m_rdata,
  output logic                   m_ready,
  output logic                   m_err,
  output logic [NSLV-1:0]        s_sel,
  output logic                   s_we,
  output logic [ADDR_W-1:0]      s_addr,
  output logic [DATA_W-1:0]      s_wdata,
  input  logic [NSLV*DATA_W-1:0] s_rdata,
  input  logic [NSLV-1:0]        s_ack
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [NSLV-1:0]     sel_d;
  logic                ready_d, err_d, we_d;
  logic [DATA_W-1:0]   rdata_d, wdata_d;
  logic [ADDR_W-1:0]   addr_d;

  logic                hit;
  logic [IW-1:0]       hit_idx;
  logic [3:0]          wait_hit;
  logic                ack_sel;
  logic [DATA_W-1:0]   rdata_sel;

  // Scan from the top index down so the lowest matching window is the last writer and wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
          (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W])) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  always_comb begin
    wait_hit  = 4'd0;
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (hit_idx == IW'(i)) begin
        wait_hit = SLV_WAIT[i*4 +: 4];
      end
      if (idx_q == IW'(i)) begin
        ack_sel   = s_ack[i];
        rdata_sel = s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    sel_d   = s_sel;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = m_rdata;
    we_d    = s_we;
    addr_d  = s_addr;
    wdata_d = s_wdata;

    case (state_q)
      IDLE: begin
        if (m_req) begin
          we_d    = m_we;
          addr_d  = m_addr;
          wdata_d = m_wdata;
          if (hit) begin
            sel_d   = NSLV'(1) << hit_idx;
            idx_d   = hit_idx;
            wcnt_d  = wait_hit;
            tcnt_d  = '0;
            state_d = ACCESS;
          end else begin
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end
        end
      end

      ACCESS: begin
        if (tcnt_q != {TW{1'b1}}) begin
          tcnt_d = tcnt_q + TW'(1);
        end
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end
        // A late ack on the last allowed cycle still completes the transfer cleanly.
        if ((wcnt_q == 4'd0) && ack_sel) begin
          rdata_d = rdata_sel;
          ready_d = 1'b1;
          sel_d   = '0;
          state_d = RESP;
        end else if (tcnt_q == T_LAST) begin
          rdata_d = '0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          sel_d   = '0;
          state_d = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wcnt_q  <= 4'd0;
      tcnt_q  <= '0;
      s_sel   <= '0;
      m_ready <= 1'b0;
      m_err   <= 1'b0;
      m_rdata <= '0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      s_sel   <= sel_d;
      m_ready <= ready_d;
      m_err   <= err_d;
      m_rdata <= rdata_d;
      s_we    <= we_d;
      s_addr  <= addr_d;
      s_wdata <= wdata_d;
    end
  end

endmodule
